// File: rtl/led_flash_sequencer_if.sv
// Host-side timing variables and LED-side status for the flash sequencer.
// The master drives start/abort and the latched variables; the slave is the sequencer.
interface led_flash_sequencer_if #(
    parameter int NUM_LED = 8
);
    logic               start;
    logic               abort;
    logic [31:0]        led_num;
    logic [31:0]        led_dly;
    logic [31:0]        led_exp;
    logic [31:0]        led_ctl;
    logic [31:0]        led_seq;
    logic [NUM_LED-1:0] led_out;
    logic               busy;
    logic               done;
    logic [2:0]         slot_idx;

    modport master (
        output start, abort, led_num, led_dly, led_exp, led_ctl, led_seq,
        input  led_out, busy, done, slot_idx
    );

    modport slave (
        input  start, abort, led_num, led_dly, led_exp, led_ctl, led_seq,
        output led_out, busy, done, slot_idx
    );
endinterface

// File: rtl/led_flash_sequencer.sv
// Exposure-triggered contrast LED sequencer: per slot an off-gap of LedDly cycles,
// then one LED (from the LedSeq nibble) held for LedExp cycles.
module led_flash_sequencer #(
    parameter int NUM_LED = 8,
    parameter int CNT_W   = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    led_flash_sequencer_if.slave bus
);
    localparam int NUM_W = $clog2(NUM_LED + 1);

    typedef enum logic [2:0] {IDLE, ARM, GAP, ON, FIN} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [NUM_W-1:0]   num_p0;
    logic [CNT_W-1:0]   dly_p0;
    logic [CNT_W-1:0]   exp_p0;
    logic [31:0]        seq_p0;
    logic [2:0]         slot_r;
    logic [NUM_LED-1:0] led_r;
    logic               busy_r;
    logic               done_r;

    logic [2:0]         ent_slot;
    logic [NUM_LED-1:0] ent_led;
    logic [NUM_LED-1:0] cur_led;
    logic               last_slot;
    logic               unused_ctl;

    function automatic logic [NUM_W-1:0] sat_num(input logic [31:0] n);
        if (n > 32'(NUM_LED)) return NUM_W'(NUM_LED);
        return n[NUM_W-1:0];
    endfunction

    // Codes outside 1..NUM_LED decode to a dark slot.
    function automatic logic [NUM_LED-1:0] led_decode(input logic [3:0] code);
        logic [NUM_LED-1:0] oh;
        oh = '0;
        for (int i = 0; i < NUM_LED; i++) oh[i] = (int'(code) == i + 1);
        return oh;
    endfunction

    assign unused_ctl = ^bus.led_ctl[31:1];

    always_comb begin
        ent_slot  = (state == ARM) ? 3'd0 : slot_r + 3'd1;
        ent_led   = led_decode(seq_p0[{ent_slot, 2'b00} +: 4]);
        cur_led   = led_decode(seq_p0[{slot_r, 2'b00} +: 4]);
        last_slot = (NUM_W'(slot_r) == num_p0 - NUM_W'(1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            num_p0 <= '0;
            dly_p0 <= '0;
            exp_p0 <= '0;
            seq_p0 <= '0;
            slot_r <= '0;
            led_r  <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (state != IDLE && bus.abort) begin
                state  <= IDLE;
                led_r  <= '0;
                busy_r <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.start && bus.led_ctl[0]) begin
                            num_p0 <= sat_num(bus.led_num);
                            dly_p0 <= CNT_W'(bus.led_dly);
                            exp_p0 <= CNT_W'(bus.led_exp);
                            seq_p0 <= bus.led_seq;
                            slot_r <= '0;
                            state  <= ARM;
                        end
                    end
                    // Parameters are stable here; zero-length phases are skipped in this edge.
                    ARM: begin
                        if (num_p0 == '0) begin
                            done_r <= 1'b1;
                            state  <= FIN;
                        end else if (dly_p0 != '0) begin
                            busy_r <= 1'b1;
                            state  <= GAP;
                            cnt    <= dly_p0 - CNT_W'(1);
                        end else if (exp_p0 != '0) begin
                            busy_r <= 1'b1;
                            state  <= ON;
                            cnt    <= exp_p0 - CNT_W'(1);
                            led_r  <= ent_led;
                        end else begin
                            done_r <= 1'b1;
                            state  <= FIN;
                        end
                    end
                    GAP, ON: begin
                        if (cnt != '0) begin
                            cnt <= cnt - CNT_W'(1);
                        end else if (state == GAP && exp_p0 != '0) begin
                            state <= ON;
                            cnt   <= exp_p0 - CNT_W'(1);
                            led_r <= cur_led;
                        end else if (last_slot) begin
                            state  <= FIN;
                            led_r  <= '0;
                            busy_r <= 1'b0;
                            done_r <= 1'b1;
                        end else begin
                            // With no gap, the next slot's LED replaces this one in the same edge.
                            slot_r <= ent_slot;
                            if (dly_p0 != '0) begin
                                state <= GAP;
                                cnt   <= dly_p0 - CNT_W'(1);
                                led_r <= '0;
                            end else begin
                                state <= ON;
                                cnt   <= exp_p0 - CNT_W'(1);
                                led_r <= ent_led;
                            end
                        end
                    end
                    FIN:     state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.led_out  = led_r;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.slot_idx = slot_r;
endmodule

// File: tb/tb_led_flash_sequencer.sv
// Bench for led_flash_sequencer: per-cycle expectations derived from the slot timing
// formulas are queued at start and popped against the DUT each cycle.
module tb_led_flash_sequencer;
    logic clk = 1'b0;
    logic rst_n;

    led_flash_sequencer_if #(.NUM_LED(8)) io ();

    led_flash_sequencer #(.NUM_LED(8), .CNT_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (io)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] ctl;
        logic [31:0] num;
        logic [31:0] dly;
        logic [31:0] expo;
        logic [31:0] seq;
        int          done_ofs;
    } vec_t;

    typedef struct {
        int       cyc;
        logic [7:0] led;
        logic     busy;
        logic     done;
        int       slot;
    } exp_t;

    exp_t q[$];
    vec_t vecs[9];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(input string nm, input logic [31:0] ctl, input logic [31:0] num,
                                input logic [31:0] dly, input logic [31:0] expo,
                                input logic [31:0] seq, input int done_ofs);
        vec_t v;
        v.name = nm; v.ctl = ctl; v.num = num; v.dly = dly;
        v.expo = expo; v.seq = seq; v.done_ofs = done_ofs;
        return v;
    endfunction

    // Expected outputs after edge t0+c, from the rise/fall/done formulas.
    task automatic build(input vec_t v, input int kill_cyc, input bit kill_rst, output int len);
        longint n, d, e, dofs, lo, rise, fall;
        bit     en;
        logic [3:0] code;
        exp_t   x;
        en   = v.ctl[0];
        n    = (v.num > 32'd8) ? 8 : v.num;
        d    = v.dly;
        e    = v.expo;
        dofs = 1 + n * (d + e);
        if (kill_cyc >= 0)   len = kill_cyc + 5;
        else if (!en)        len = 4;
        else if (dofs + 2 > 60) len = 60;
        else                 len = int'(dofs) + 2;
        for (int c = 0; c <= len; c++) begin
            x.cyc = c; x.led = '0; x.busy = 1'b0; x.done = 1'b0; x.slot = -1;
            if (kill_cyc >= 0 && c > kill_cyc) begin
                if (kill_rst) x.slot = 0;
            end else if (en) begin
                x.busy = (c >= 1 && c < dofs);
                x.done = (c == dofs);
                for (int k = 0; k < n; k++) begin
                    lo   = 1 + k * (d + e);
                    rise = lo + d;
                    fall = 1 + (k + 1) * (d + e);
                    if (c >= lo && c < fall) x.slot = k;
                    if (c >= rise && c < fall) begin
                        code = v.seq[4*k +: 4];
                        if (code >= 4'd1 && code <= 4'd8) x.led[code - 4'd1] = 1'b1;
                    end
                end
            end
            q.push_back(x);
        end
    endtask

    task automatic check_idle(input string nm);
        checks++;
        if (io.led_out !== 8'h00 || io.busy !== 1'b0 || io.done !== 1'b0 || io.slot_idx !== 3'd0) begin
            errors++;
            $display("FAIL %s got led=%h busy=%b done=%b slot=%0d want all zero",
                     nm, io.led_out, io.busy, io.done, io.slot_idx);
        end
    endtask

    task automatic run(input vec_t v, input int poke_cyc, input int kill_cyc,
                       input bit kill_rst, input bit abort_w_start);
        int   len;
        int   seen_done;
        exp_t x;
        build(v, kill_cyc, kill_rst, len);
        io.led_ctl = v.ctl; io.led_num = v.num; io.led_dly = v.dly;
        io.led_exp = v.expo; io.led_seq = v.seq;
        io.start = 1'b1;
        io.abort = abort_w_start;
        @(posedge clk); #1;
        io.start = 1'b0;
        seen_done = -1;
        for (int c = 0; c <= len; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            x = q.pop_front();
            checks++;
            if (io.led_out !== x.led || io.busy !== x.busy || io.done !== x.done ||
                (x.slot >= 0 && {29'd0, io.slot_idx} !== 32'(x.slot))) begin
                errors++;
                $display("FAIL %s c=%0d got led=%h busy=%b done=%b slot=%0d want led=%h busy=%b done=%b slot=%0d",
                         v.name, c, io.led_out, io.busy, io.done, io.slot_idx,
                         x.led, x.busy, x.done, x.slot);
            end
            checks++;
            if ($countones(io.led_out) > 1) begin
                errors++;
                $display("FAIL %s_onehot c=%0d got led=%h want at most one bit", v.name, c, io.led_out);
            end
            if (io.done === 1'b1 && seen_done < 0) seen_done = c;
            if (c == poke_cyc) begin io.led_exp = 32'd50; io.start = 1'b1; end
            if (c == poke_cyc + 1) io.start = 1'b0;
            if (c == kill_cyc) begin
                if (kill_rst) rst_n = 1'b0;
                else io.abort = 1'b1;
            end
            if (c == kill_cyc + 1) begin rst_n = 1'b1; io.abort = 1'b0; end
        end
        checks++;
        if (seen_done != v.done_ofs) begin
            errors++;
            $display("FAIL %s_done_cycle got %0d want %0d", v.name, seen_done, v.done_ofs);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = mk("basic",    32'd1,          32'd2,  32'd3, 32'd5, 32'h00000021, 17);
        vecs[1] = mk("disabled", 32'd0,          32'd2,  32'd3, 32'd5, 32'h00000021, -1);
        vecs[2] = mk("empty",    32'd1,          32'd0,  32'd3, 32'd5, 32'h00000021, 1);
        vecs[3] = mk("clamp",    32'd1,          32'd12, 32'd0, 32'd2, 32'h80654321, 17);
        vecs[4] = mk("exp_zero", 32'd1,          32'd3,  32'd2, 32'd0, 32'h00000321, 7);
        vecs[5] = mk("dark_hi",  32'd1,          32'd2,  32'd1, 32'd3, 32'h000000F9, 9);
        vecs[6] = mk("all_zero", 32'd1,          32'd5,  32'd0, 32'd0, 32'h00054321, 1);
        vecs[7] = mk("ctl_hi0",  32'hFFFFFFFE,   32'd2,  32'd1, 32'd1, 32'h00000012, -1);
        vecs[8] = mk("ctl_hi1",  32'h80000001,   32'd1,  32'd0, 32'd1, 32'h00000008, 2);

        rst_n = 1'b0;
        io.start = 1'b0; io.abort = 1'b0;
        io.led_ctl = '0; io.led_num = '0; io.led_dly = '0; io.led_exp = '0; io.led_seq = '0;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_idle("post_reset");

        for (int i = 0; i < 9; i++) run(vecs[i], -1, -1, 1'b0, 1'b0);

        // Mid-run change of led_exp plus a re-trigger while busy.
        run(vecs[0], 6, -1, 1'b0, 1'b0);
        // Abort coincident with start in IDLE: start wins.
        run(vecs[0], -1, -1, 1'b0, 1'b1);
        // Abort during slot 1 ON.
        run(mk("abort_on", 32'd1, 32'd2, 32'd3, 32'd5, 32'h00000021, -1), -1, 13, 1'b0, 1'b0);
        // Reset pulse mid-GAP, then a fresh run.
        run(mk("rst_gap", 32'd1, 32'd2, 32'd3, 32'd5, 32'h00000021, -1), -1, 2, 1'b1, 1'b0);
        run(vecs[0], -1, -1, 1'b0, 1'b0);
        // Maximum delay stays in GAP without wrapping, then is aborted.
        run(mk("long_dly", 32'd1, 32'd1, 32'hFFFFFFFF, 32'd1, 32'h00000008, -1), -1, 20, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/led_flash_sequencer.md
Name: led_flash_sequencer

Overview:
- Downstream consumer of the host-writable timing-variable register block.
- Takes the LED variables LedNum, LedDly, LedExp, LedCtl and LedSeq, and on each exposure-start pulse drives up to 8 contrast LEDs in the programmed order, one LED per slot.
- Sits between the variable register block and the LED driver pins. It is triggered by the exposure controller.

Parameters:
- NUM_LED, 8, number of LED outputs; LedSeq holds NUM_LED 4-bit slot codes.
- CNT_W, 32, width of the delay and on-time counters; matches the 32-bit variable width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  single-cycle exposure-start pulse.
- abort  in  1  single-cycle request to terminate the sequence.
- led_num  in  32  LedNum: number of slots to run.
- led_dly  in  32  LedDly: off-gap in cycles before each slot's flash.
- led_exp  in  32  LedExp: on-time in cycles per slot.
- led_ctl  in  32  LedCtl: bit0 enables the sequencer; bits 31:1 are ignored.
- led_seq  in  32  LedSeq: nibble k (bits 4k+3:4k) is the LED code for slot k.
- led_out  out  NUM_LED  one-hot LED drive, registered.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  single-cycle pulse when a sequence completes.
- slot_idx  out  3  index of the current slot, registered.

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE; led_out=0, busy=0, done=0, slot_idx=0; all counters and latched parameters are 0.
- Accepting a start:
  - start is accepted only in IDLE with led_ctl[0]=1.
  - start while busy is ignored. start with led_ctl[0]=0 is ignored: no busy, no done.
- Parameter latching:
  - On acceptance, led_num, led_dly, led_exp and led_seq are latched.
  - Later changes to these inputs have no effect until the next accepted start.
- Slot count: N = min(led_num, NUM_LED). A led_num above 8 is clamped to 8.
- States: IDLE, GAP, ON, FIN.
  - IDLE -> GAP on accepted start, with slot_idx=0. If N=0, go to FIN instead.
  - GAP: count D=led_dly cycles with led_out=0, then -> ON. If D=0, GAP lasts 0 cycles and ON is entered directly.
  - ON: led_out = one-hot of (code-1) for the current slot's nibble, held for E=led_exp cycles.
  - ON exit: if this is the last slot, -> FIN. Otherwise increment slot_idx and -> GAP.
  - FIN: led_out=0, done=1 for exactly one cycle, busy=0 -> IDLE.
- Timing (start sampled at edge t0):
  - Slot k LED rises at edge t0+1+(k+1)D+kE and falls at edge t0+1+(k+1)(D+E).
  - done is high for the cycle starting at the last fall edge, t0+1+N(D+E).
  - busy is high from edge t0+1 until that same edge.
- Code rules:
  - Codes 1..8 select LED 0..7.
  - Code 0 or codes 9..15 give a dark slot: led_out stays 0, but slot timing is fully preserved.
  - E=0 makes every slot zero-length: no LED pulse, and slots advance back-to-back through their GAP periods.
- Invariant: at most one bit of led_out is ever high. There is no overlap between slots, even when D=0.
- Abort: abort in any non-IDLE state forces led_out=0, busy=0 and state IDLE at the next edge. done is not asserted. If abort and start arrive in the same cycle while IDLE, start wins.
- Reset mid-sequence has the same effect as the reset values above. No done is emitted.
- Counters: internal down-counters are CNT_W wide and do not wrap. A delay of 32'hFFFFFFFF is a legal long count.

Test Plan:
- Basic two-slot run:
  - Stimulus: reset, then led_ctl=1, led_num=2, led_dly=3, led_exp=5, led_seq=32'h00000021, start at t0.
  - Required: LED0 high edges t0+4..t0+9; LED1 high edges t0+12..t0+17; done at t0+17; busy t0+1..t0+17.
- Disabled and empty runs:
  - Stimulus: led_ctl=0 with start.
  - Required: no busy, no done, led_out=0.
  - Stimulus: led_ctl=1, led_num=0, start.
  - Required: done at t0+1, with busy and led_out staying 0.
- Clamping and dark slot:
  - Stimulus: led_num=12, led_dly=0, led_exp=2, led_seq=32'h80654321.
  - Required: 8 slots run; slot 6 (code 0) is dark for 2 cycles; slot 7 drives LED7; done at t0+17; led_out is always one-hot or zero.
- Latching and re-trigger:
  - Stimulus: change led_exp from 5 to 50 mid-run, and pulse start again while busy.
  - Required: the current run keeps E=5, the second start is ignored, and a single done is produced.
- Abort and reset:
  - Stimulus: abort during slot 1 ON.
  - Required: led_out=0 and busy=0 next edge, with no done.
  - Stimulus: a second run with rst_n low for 1 cycle mid-GAP.
  - Required: all outputs 0 next edge; a fresh start afterward runs normally.
